// File: rtl/bcd_countdown_chain_pkg.sv
// Shared timer definitions: digit width, per-modulus digit maxima, modulus lookup.
// No logic of its own; consumed at elaboration time.
// No flow control.
package bcd_countdown_chain_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;

  localparam logic [BCD_W-1:0] DIGIT_MAX10 = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX6  = 4'd5;

  // Modulus of digit idx: a set mask bit selects a seconds-tens style mod-6 digit.
  function automatic int digit_mod(input logic [MAX_DIGITS-1:0] mask, input int idx);
    logic [MAX_DIGITS-1:0] sh;
    sh = mask >> idx;
    return sh[0] ? 6 : 10;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the countdown chain with clamped load, borrow and carry links.
// New value one cycle after the sampling edge; borrow/carry outputs are combinational.
// No backpressure; the chain decides which single request reaches the cell each cycle.
module bcd_digit_cell
  import bcd_countdown_chain_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic             dec,
  input  logic             borrow_in,
  output logic             borrow_out,
  input  logic             inc,
  input  logic             carry_in,
  output logic             carry_out,
  input  logic             load,
  input  logic [BCD_W-1:0] d_in,
  output logic [BCD_W-1:0] q
);

  localparam logic [BCD_W-1:0] MAX = (MOD == 6) ? DIGIT_MAX6 : DIGIT_MAX10;

  logic [BCD_W-1:0] q_nxt;
  logic [BCD_W-1:0] d_clamp;

  // A digit sitting at 0 that is asked to decrement must borrow from above.
  assign borrow_out = borrow_in & (q == '0);
  // A digit sitting at its max that is asked to increment must carry upward.
  assign carry_out  = carry_in & (q == MAX);

  // Out-of-range load values are pinned to the digit maximum.
  always_comb begin
    d_clamp = d_in;
    if (d_in > MAX) d_clamp = MAX;
  end

  // Next digit value: load beats increment beats decrement.
  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = d_clamp;
    end else if (inc && carry_in) begin
      q_nxt = carry_out ? '0 : q + 4'd1;
    end else if (dec && borrow_in) begin
      q_nxt = borrow_out ? MAX : q - 4'd1;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) q <= '0;
    else         q <= q_nxt;
  end

endmodule

// File: rtl/bcd_countdown_chain.sv
// Cascaded BCD down-counter with clamped load, quick-add increment, zero hold/wrap and done pulse.
// bcd_out/zero update one cycle after the sampling edge; done is a registered one-cycle pulse.
// No backpressure; lower-priority requests in a cycle are dropped, never queued.
module bcd_countdown_chain
  import bcd_countdown_chain_pkg::*;
#(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] MOD6_MASK  = 4'b0010,
  parameter int                    WRAP       = 0,
  parameter int                    INC_DIGIT  = 1
) (
  input  logic                        clk,
  input  logic                        clearn,
  input  logic                        loadn,
  input  logic                        enable,
  input  logic                        inc,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  output logic [BCD_W*NUM_DIGITS-1:0] bcd_out,
  output logic                        zero,
  output logic                        tc,
  output logic                        done
);

  localparam int CNT_W = BCD_W * NUM_DIGITS;

  logic              load_sel;
  logic              inc_sel;
  logic              dec_req;
  logic              dec_go;
  logic              sat;
  logic              cell_load;
  logic              one_left;
  logic [CNT_W-1:0]  load_dat;
  logic [NUM_DIGITS:0] borrow;
  logic [NUM_DIGITS:0] carry;

  // Digit 0 always receives the decrement; nothing carries into the bottom of the chain.
  assign borrow[0] = 1'b1;
  assign carry[0]  = 1'b0;

  // Priority decode. A borrow leaving the top digit means the count is zero: hold unless
  // wrapping, in which case every digit borrows and reloads its max. A carry leaving the
  // top digit saturates the count by loading all-ones, which each cell clamps to its max.
  always_comb begin
    load_sel  = ~loadn;
    inc_sel   = loadn & inc;
    dec_req   = loadn & ~inc & enable;
    dec_go    = dec_req & ((WRAP != 0) | ~borrow[NUM_DIGITS]);
    sat       = inc_sel & carry[NUM_DIGITS];
    cell_load = load_sel | sat;
    load_dat  = load_sel ? bcd_in : '1;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    localparam bit INC_HERE = (g == INC_DIGIT);

    bcd_digit_cell #(
      .MOD (digit_mod(MAX_DIGITS'(MOD6_MASK), g))
    ) u_cell (
      .clk        (clk),
      .clearn     (clearn),
      .dec        (dec_go),
      .borrow_in  (borrow[g]),
      .borrow_out (borrow[g+1]),
      .inc        (inc_sel),
      .carry_in   (carry[g] | INC_HERE),
      .carry_out  (carry[g+1]),
      .load       (cell_load),
      .d_in       (load_dat[g*BCD_W +: BCD_W]),
      .q          (bcd_out[g*BCD_W +: BCD_W])
    );
  end

  assign zero     = (bcd_out == '0);
  assign tc       = enable & zero;
  assign one_left = (bcd_out == CNT_W'(1));

  // done fires only when a real decrement takes the count from one to zero.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) done <= 1'b0;
    else         done <= dec_go & one_left;
  end

endmodule

// File: tb/tb_bcd_countdown_chain.sv
module tb_bcd_countdown_chain;

  logic        clk    = 1'b0;
  logic        clearn = 1'b1;
  logic        loadn  = 1'b1;
  logic        enable = 1'b0;
  logic        inc    = 1'b0;
  logic [15:0] bcd_in = '0;

  logic [15:0] bcd_out, w_bcd_out;
  logic        zero, tc, done;
  logic        w_zero, w_tc, w_done;

  bcd_countdown_chain #(
    .NUM_DIGITS (4), .MOD6_MASK (4'b0010), .WRAP (0), .INC_DIGIT (1)
  ) u_dut (
    .clk (clk), .clearn (clearn), .loadn (loadn), .enable (enable), .inc (inc),
    .bcd_in (bcd_in), .bcd_out (bcd_out), .zero (zero), .tc (tc), .done (done)
  );

  bcd_countdown_chain #(
    .NUM_DIGITS (4), .MOD6_MASK (4'b0010), .WRAP (1), .INC_DIGIT (1)
  ) u_dut_wrap (
    .clk (clk), .clearn (clearn), .loadn (loadn), .enable (enable), .inc (inc),
    .bcd_in (bcd_in), .bcd_out (w_bcd_out), .zero (w_zero), .tc (w_tc), .done (w_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] bcd;
    logic        z, t, d;
    bit          chk_w;
    logic [15:0] wbcd;
    logic        wz, wt, wd;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected state after the next rising edge is queued at the falling edge that drives it.
  task automatic step(input string name, input logic ld_n, input logic en, input logic inc_i,
                      input logic [15:0] din, input logic [15:0] eb, input logic ez,
                      input logic et, input logic ed, input bit cw = 1'b0,
                      input logic [15:0] wb = '0, input logic wz = 1'b0,
                      input logic wt = 1'b0, input logic wd = 1'b0);
    exp_t e;
    @(negedge clk);
    loadn  = ld_n;
    enable = en;
    inc    = inc_i;
    bcd_in = din;
    e.name = name; e.bcd = eb; e.z = ez; e.t = et; e.d = ed;
    e.chk_w = cw; e.wbcd = wb; e.wz = wz; e.wt = wt; e.wd = wd;
    sb.push_back(e);
  endtask

  // Monitor: checks the registered state a little after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".bcd"},  32'(bcd_out), 32'(e.bcd));
        chk({e.name, ".zero"}, 32'(zero),    32'(e.z));
        chk({e.name, ".tc"},   32'(tc),      32'(e.t));
        chk({e.name, ".done"}, 32'(done),    32'(e.d));
        if (e.chk_w) begin
          chk({e.name, ".w_bcd"},  32'(w_bcd_out), 32'(e.wbcd));
          chk({e.name, ".w_zero"}, 32'(w_zero),    32'(e.wz));
          chk({e.name, ".w_tc"},   32'(w_tc),      32'(e.wt));
          chk({e.name, ".w_done"}, 32'(w_done),    32'(e.wd));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 clearn = 1'b0;
    #1;
    chk("rst.bcd",  32'(bcd_out), 32'h0);
    chk("rst.zero", 32'(zero),    32'h1);
    chk("rst.done", 32'(done),    32'h0);
    chk("rst.tc0",  32'(tc),      32'h0);
    enable = 1'b1;
    #1;
    chk("rst.tc1",  32'(tc),      32'h1);
    enable = 1'b0;
    @(negedge clk);
    clearn = 1'b1;

    // Countdown through a mod-6 borrow
    step("ld0105", 0, 0, 0, 16'h0105, 16'h0105, 0, 0, 0);
    step("t1",     1, 1, 0, 16'h0,    16'h0104, 0, 0, 0);
    step("t2",     1, 1, 0, 16'h0,    16'h0103, 0, 0, 0);
    step("t3",     1, 1, 0, 16'h0,    16'h0102, 0, 0, 0);
    step("t4",     1, 1, 0, 16'h0,    16'h0101, 0, 0, 0);
    step("t5",     1, 1, 0, 16'h0,    16'h0100, 0, 0, 0);
    step("t6",     1, 1, 0, 16'h0,    16'h0059, 0, 0, 0);

    // Reach zero, done pulse, hold vs wrap
    step("ld0002", 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
    step("z1",     1, 1, 0, 16'h0,    16'h0001, 0, 0, 0);
    step("z2",     1, 1, 0, 16'h0,    16'h0000, 1, 1, 1, 1, 16'h0000, 1, 1, 1);
    step("z3",     1, 1, 0, 16'h0,    16'h0000, 1, 1, 0, 1, 16'h9959, 0, 0, 0);
    #1;
    chk("z3.pre_tc",   32'(tc),   32'h1);
    chk("z3.pre_w_tc", 32'(w_tc), 32'h1);
    step("idle",   1, 0, 0, 16'h0,    16'h0000, 1, 0, 0, 1, 16'h9959, 0, 0, 0);

    // Quick-add with carry and saturation
    step("ld0055", 0, 0, 0, 16'h0055, 16'h0055, 0, 0, 0);
    step("inc1",   1, 0, 1, 16'h0,    16'h0105, 0, 0, 0);
    step("ld9955", 0, 0, 0, 16'h9955, 16'h9955, 0, 0, 0);
    step("incsat", 1, 0, 1, 16'h0,    16'h9959, 0, 0, 0);
    step("ld0100", 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
    step("incen",  1, 1, 1, 16'h0,    16'h0110, 0, 0, 0);

    // Load clamping, load beats inc and enable
    step("ldclamp", 0, 1, 1, 16'h0ACF, 16'h0959, 0, 0, 0);

    // inc from zero
    step("ld0000", 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    step("inczero", 1, 0, 1, 16'h0,   16'h0010, 0, 0, 0);

    // Reach zero again, then clear asynchronously while done is high
    step("ld0001", 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
    step("to0",    1, 1, 0, 16'h0,    16'h0000, 1, 1, 1, 1, 16'h0000, 1, 1, 1);
    @(posedge clk);
    #4;
    clearn = 1'b0;
    #1;
    chk("clrA.done",   32'(done),   32'h0);
    chk("clrA.w_done", 32'(w_done), 32'h0);
    @(negedge clk);
    clearn = 1'b1;

    // Clear asynchronously with a non-zero count
    step("ld0959", 0, 0, 0, 16'h0959, 16'h0959, 0, 0, 0);
    step("t0958",  1, 1, 0, 16'h0,    16'h0958, 0, 0, 0);
    @(posedge clk);
    #4;
    clearn = 1'b0;
    #1;
    chk("clrB.bcd",   32'(bcd_out),   32'h0);
    chk("clrB.zero",  32'(zero),      32'h1);
    chk("clrB.tc",    32'(tc),        32'h1);
    chk("clrB.w_bcd", 32'(w_bcd_out), 32'h0);
    @(negedge clk);
    enable = 1'b0;
    clearn = 1'b1;

    begin
      int k;
      k = 0;
      while (sb.size() > 0 && k < 20) begin
        @(posedge clk);
        #3;
        k++;
      end
      nchk++;
      if (sb.size() > 0) begin
        nerr++;
        $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_chain.md
# bcd_countdown_chain

Parametrised multi-digit BCD down-counter for the microwave timer, replacing per-digit hand-wired counters with one cascaded chain. Each digit has a compile-time modulus (10 or 6), so the default configuration counts MM:SS with seconds-tens mod 6. It adds behaviour the single-digit counters lack:
- zero saturation or wrap mode
- a quick-add increment with upward carry
- load clamping
- a registered one-cycle done pulse

It sits between the keypad/load logic and the display/controller FSM.

## Interface
Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
- MOD6_MASK, 4'b0010 (width NUM_DIGITS), bit i set means digit i counts mod 6, otherwise mod 10.
- WRAP, 0, 0 = hold at zero; 1 = roll from all-zero to all-max.
- INC_DIGIT, 1, digit index incremented by inc (default +10 s).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- clearn  in  1  reset, asynchronous, active-low; clears the counter.
- loadn  in  1  synchronous active-low load of bcd_in.
- enable  in  1  count tick; decrement by one when high.
- inc  in  1  synchronous increment request at digit INC_DIGIT.
- bcd_in  in  4*NUM_DIGITS  load value, digit i at [4i+3:4i].
- bcd_out  out  4*NUM_DIGITS  current count.
- zero  out  1  count is all-zero (combinational from register).
- tc  out  1  enable & zero, combinational.
- done  out  1  registered one-cycle pulse on reaching zero by decrement.

## Operation
- Per-edge priority: clearn (async) > loadn low > inc > enable. Only the highest-priority request acts; lower ones in that cycle are dropped, not queued.
- Load: each digit takes bcd_in digit, clamped to modulus-1 if ≥ modulus (e.g. 4'hC in a mod-6 digit loads 5; 4'hA in mod-10 loads 9). Load never asserts done.
- Decrement (enable, count ≠ 0): digit 0 decrements. A borrow passes upward while the lower digit is 0; each borrowing digit reloads modulus-1.
- Decrement at zero:
  - WRAP=0: count holds, done stays low, tc high.
  - WRAP=1: count becomes all-max (e.g. 99:59), tc high that cycle, done low.
- done: set on the edge where a decrement moves count from non-zero to zero; cleared next edge.
- inc: digit INC_DIGIT adds 1. Carry ripples upward on modulus overflow (digit goes to 0). Lower digits are unchanged.
  - If the carry exits the top digit, the whole count saturates to all-max.
  - inc on zero count is legal, clears zero, and never asserts done.
- Reset values: bcd_out 0, zero 1, done 0, tc = enable.

## Timing
- Load, inc and decrement results are visible on bcd_out one cycle after the sampling edge; zero follows in the same cycle.
- done is high in the cycle immediately after the edge that produced zero, for exactly one cycle.
- tc and zero are combinational from registered state. No input-to-output combinational path exists except enable→tc.
- Mid-operation clearn assertion zeroes the count and done immediately; deassertion is synchronised upstream.
- Back-to-back enable every cycle is supported. No throughput limit.

## Structure
- Shared timer package/header:
  - BCD_W=4
  - digit-max constants (9, 5)
  - a function returning the modulus for digit i from MOD6_MASK
- Sub-module bcd_digit_cell, instantiated NUM_DIGITS times in a generate loop.
  - Parameter: MOD.
  - Ports:
    - dec, borrow_in, borrow_out
    - inc, carry_in, carry_out
    - load, d_in
    - q
  - The chain module owns priority decode, zero/saturation detection and the done register.

## Test plan
- Reset then load 01:05 (bcd_in 16'h0105), 5 enable ticks → bcd_out 16'h0100; next tick → 16'h0059 (mod-6 borrow), no done.
- Load 00:02, 2 ticks → 16'h0000, zero=1, done high exactly one cycle after second tick; third tick with WRAP=0 → holds 0, tc=1, done=0.
- WRAP=1, count 0, one tick → 16'h9959, tc high during that cycle, done stays 0.
- Load 00:55, inc → 16'h0105; load 99:55, inc → saturates 16'h9959; inc and enable same cycle → only inc applied.
- Load 16'h0ACF → clamps to 16'h0959; loadn with enable and inc same cycle → loaded value only.
- Assert clearn mid-countdown between edges → bcd_out 0 and done 0 immediately, no clock needed.
